// File: rtl/fwd_source_pipe.sv
// EX/MEM + MEM/WB result pipeline feeding forwarding, writeback and load-use stall detection.
// Define FWD_SOURCE_STATS_EN to add the saturating stallCount load-use stall counter.
module fwd_source_pipe #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned REG_W    = 5,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exValid,
    input  logic              exRegWrite,
    input  logic              exIsLoad,
    input  logic [REG_W-1:0]  exReg,
    input  logic [DATA_W-1:0] exResult,
    input  logic [DATA_W-1:0] memLoadData,
    input  logic              memStall,
    input  logic              flush,
    input  logic [REG_W-1:0]  idReg1,
    input  logic [REG_W-1:0]  idReg2,
    input  logic              idUses1,
    input  logic              idUses2,
    output logic [REG_W-1:0]  ALUreg,
    output logic [REG_W-1:0]  MEMreg,
    output logic [DATA_W-1:0] ALUdata,
    output logic [DATA_W-1:0] MEMdata,
    output logic              ALUforward,
    output logic              MEMforward,
    output logic [REG_W-1:0]  wbReg,
    output logic [DATA_W-1:0] wbData,
    output logic              wbWrite,
    output logic              loadUseStall
`ifdef FWD_SOURCE_STATS_EN
    ,
    output logic [31:0]       stallCount
`endif
);

    localparam logic [REG_W-1:0] ZeroReg = REG_W'(ZERO_REG);

    // EX/MEM entry
    logic              em_valid_q;
    logic              em_reg_write_q;
    logic              em_is_load_q;
    logic [REG_W-1:0]  em_reg_q;
    logic [DATA_W-1:0] em_result_q;

    // MEM/WB entry
    logic              mw_valid_q;
    logic              mw_reg_write_q;
    logic [REG_W-1:0]  mw_reg_q;
    logic [DATA_W-1:0] mw_data_q;
    logic              mw_wb_done_q;

    logic em_writes_real;
    logic src1_hit;
    logic src2_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            em_valid_q     <= 1'b0;
            em_reg_write_q <= 1'b0;
            em_is_load_q   <= 1'b0;
            em_reg_q       <= '0;
            em_result_q    <= '0;
            mw_valid_q     <= 1'b0;
            mw_reg_write_q <= 1'b0;
            mw_reg_q       <= '0;
            mw_data_q      <= '0;
            mw_wb_done_q   <= 1'b0;
        end else if (!memStall) begin
            em_valid_q     <= exValid & ~flush;
            em_reg_write_q <= exRegWrite;
            em_is_load_q   <= exIsLoad;
            em_reg_q       <= exReg;
            em_result_q    <= exResult;
            mw_valid_q     <= em_valid_q;
            mw_reg_write_q <= em_reg_write_q;
            mw_reg_q       <= em_reg_q;
            mw_data_q      <= em_is_load_q ? memLoadData : em_result_q;
            mw_wb_done_q   <= 1'b0;
        end else begin
            // Both entries hold; remember that this entry already wrote the register file.
            mw_wb_done_q   <= mw_wb_done_q | wbWrite;
        end
    end

    always_comb begin
        em_writes_real = em_valid_q & em_reg_write_q & (em_reg_q != ZeroReg);
        src1_hit       = idUses1 & (idReg1 == em_reg_q);
        src2_hit       = idUses2 & (idReg2 == em_reg_q);

        ALUreg         = em_reg_q;
        ALUdata        = em_result_q;
        ALUforward     = em_writes_real & ~em_is_load_q;

        MEMreg         = mw_reg_q;
        MEMdata        = mw_data_q;
        MEMforward     = mw_valid_q & mw_reg_write_q & (mw_reg_q != ZeroReg);

        wbReg          = mw_reg_q;
        wbData         = mw_data_q;
        wbWrite        = MEMforward & ~mw_wb_done_q;

        loadUseStall   = em_writes_real & em_is_load_q & (src1_hit | src2_hit);
    end

`ifdef FWD_SOURCE_STATS_EN
    logic [31:0] stall_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
        end else if (loadUseStall && !memStall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign stallCount = stall_count_q;
`endif

endmodule

// File: tb/tb_fwd_source_pipe.sv
// Directed table-driven bench for fwd_source_pipe plus hand-written stall/reset sequences.
// Honours FWD_SOURCE_STATS_EN to also check stallCount.
module tb_fwd_source_pipe;

    typedef struct packed {
        logic        rst;
        logic        vld;
        logic        rw;
        logic        ld;
        logic [4:0]  rd;
        logic [63:0] res;
        logic [63:0] mld;
        logic        stall;
        logic        fl;
        logic [4:0]  id1;
        logic        u1;
        logic [4:0]  id2;
        logic        u2;
    } in_t;

    typedef struct packed {
        logic [4:0]  areg;
        logic [63:0] adata;
        logic        afwd;
        logic [4:0]  mreg;
        logic [63:0] mdata;
        logic        mfwd;
        logic        wbw;
        logic        lus;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        exValid, exRegWrite, exIsLoad, memStall, flush, idUses1, idUses2;
    logic [4:0]  exReg, idReg1, idReg2;
    logic [63:0] exResult, memLoadData;
    logic [4:0]  ALUreg, MEMreg, wbReg;
    logic [63:0] ALUdata, MEMdata, wbData;
    logic        ALUforward, MEMforward, wbWrite, loadUseStall;
`ifdef FWD_SOURCE_STATS_EN
    logic [31:0] stallCount;
`endif

    int checks = 0;
    int errors = 0;

    fwd_source_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .exValid     (exValid),
        .exRegWrite  (exRegWrite),
        .exIsLoad    (exIsLoad),
        .exReg       (exReg),
        .exResult    (exResult),
        .memLoadData (memLoadData),
        .memStall    (memStall),
        .flush       (flush),
        .idReg1      (idReg1),
        .idReg2      (idReg2),
        .idUses1     (idUses1),
        .idUses2     (idUses2),
        .ALUreg      (ALUreg),
        .MEMreg      (MEMreg),
        .ALUdata     (ALUdata),
        .MEMdata     (MEMdata),
        .ALUforward  (ALUforward),
        .MEMforward  (MEMforward),
        .wbReg       (wbReg),
        .wbData      (wbData),
        .wbWrite     (wbWrite),
        .loadUseStall(loadUseStall)
`ifdef FWD_SOURCE_STATS_EN
        ,
        .stallCount  (stallCount)
`endif
    );

    always #5 clk = ~clk;

    function automatic in_t stim(input int unsigned rst, vld, rw, ld, rd,
                                 input longint unsigned res, mld,
                                 input int unsigned stall, fl, id1, u1, id2, u2);
        in_t s;
        s.rst = 1'(rst);  s.vld = 1'(vld);  s.rw = 1'(rw);  s.ld = 1'(ld);
        s.rd = 5'(rd);    s.res = 64'(res); s.mld = 64'(mld);
        s.stall = 1'(stall); s.fl = 1'(fl);
        s.id1 = 5'(id1);  s.u1 = 1'(u1);    s.id2 = 5'(id2);  s.u2 = 1'(u2);
        return s;
    endfunction

    function automatic out_t expv(input int unsigned areg, input longint unsigned adata,
                                  input int unsigned afwd, mreg, input longint unsigned mdata,
                                  input int unsigned mfwd, wbw, lus);
        out_t e;
        e.areg = 5'(areg);  e.adata = 64'(adata); e.afwd = 1'(afwd);
        e.mreg = 5'(mreg);  e.mdata = 64'(mdata); e.mfwd = 1'(mfwd);
        e.wbw = 1'(wbw);    e.lus = 1'(lus);
        return e;
    endfunction

    task automatic drive(input in_t s);
        reset = s.rst;  exValid = s.vld;  exRegWrite = s.rw;  exIsLoad = s.ld;
        exReg = s.rd;   exResult = s.res; memLoadData = s.mld;
        memStall = s.stall; flush = s.fl;
        idReg1 = s.id1; idUses1 = s.u1;   idReg2 = s.id2;     idUses2 = s.u2;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic check(input string tag, input out_t e);
        chk({tag, ".ALUreg"},       64'(ALUreg),       64'(e.areg));
        chk({tag, ".ALUdata"},      ALUdata,           e.adata);
        chk({tag, ".ALUforward"},   64'(ALUforward),   64'(e.afwd));
        chk({tag, ".MEMreg"},       64'(MEMreg),       64'(e.mreg));
        chk({tag, ".MEMdata"},      MEMdata,           e.mdata);
        chk({tag, ".MEMforward"},   64'(MEMforward),   64'(e.mfwd));
        chk({tag, ".wbReg"},        64'(wbReg),        64'(e.mreg));
        chk({tag, ".wbData"},       wbData,            e.mdata);
        chk({tag, ".wbWrite"},      64'(wbWrite),      64'(e.wbw));
        chk({tag, ".loadUseStall"}, 64'(loadUseStall), 64'(e.lus));
    endtask

    task automatic step(input in_t s, input string tag, input out_t e);
        drive(s);
        @(posedge clk);
        #1;
        check(tag, e);
    endtask

    vec_t tbl[18];
    in_t  idle;

    initial begin
        idle = stim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset held two cycles with a live instruction on the inputs.
        tbl[0].i  = stim(1, 1, 1, 0, 3, 'h55, 0, 0, 0, 0, 0, 0, 0);
        tbl[0].o  = expv(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1].i  = stim(1, 1, 1, 0, 3, 'h55, 0, 0, 0, 0, 0, 0, 0);
        tbl[1].o  = expv(0, 0, 0, 0, 0, 0, 0, 0);
        // ALU op X3 = 5
        tbl[2].i  = stim(0, 1, 1, 0, 3, 'h5, 0, 0, 0, 0, 0, 0, 0);
        tbl[2].o  = expv(3, 'h5, 1, 0, 0, 0, 0, 0);
        tbl[3].i  = idle;
        tbl[3].o  = expv(0, 0, 0, 3, 'h5, 1, 1, 0);
        tbl[4].i  = idle;
        tbl[4].o  = expv(0, 0, 0, 0, 0, 0, 0, 0);
        // Load X7 consumed via idReg1
        tbl[5].i  = stim(0, 1, 1, 1, 7, 'h100, 0, 0, 0, 7, 1, 0, 0);
        tbl[5].o  = expv(7, 'h100, 0, 0, 0, 0, 0, 1);
        tbl[6].i  = stim(0, 0, 0, 0, 0, 0, 'hDEAD, 0, 0, 7, 1, 0, 0);
        tbl[6].o  = expv(0, 0, 0, 7, 'hDEAD, 1, 1, 0);
        // Same load, source not used
        tbl[7].i  = stim(0, 1, 1, 1, 7, 'h108, 0, 0, 0, 7, 0, 0, 0);
        tbl[7].o  = expv(7, 'h108, 0, 0, 0, 0, 0, 0);
        tbl[8].i  = stim(0, 0, 0, 0, 0, 0, 'hBEEF, 0, 0, 0, 0, 0, 0);
        tbl[8].o  = expv(0, 0, 0, 7, 'hBEEF, 1, 1, 0);
        // Load X12 consumed via idReg2 only
        tbl[9].i  = stim(0, 1, 1, 1, 12, 'h200, 0, 0, 0, 12, 0, 12, 1);
        tbl[9].o  = expv(12, 'h200, 0, 0, 0, 0, 0, 1);
        tbl[10].i = stim(0, 0, 0, 0, 0, 0, 'h77, 0, 0, 0, 0, 12, 1);
        tbl[10].o = expv(0, 0, 0, 12, 'h77, 1, 1, 0);
        // Zero register: ALU op then load, never forwarded/written/stalled
        tbl[11].i = stim(0, 1, 1, 0, 31, 'h99, 0, 0, 0, 0, 0, 0, 0);
        tbl[11].o = expv(31, 'h99, 0, 0, 0, 0, 0, 0);
        tbl[12].i = stim(0, 1, 1, 1, 31, 'h300, 0, 0, 0, 31, 1, 0, 0);
        tbl[12].o = expv(31, 'h300, 0, 31, 'h99, 0, 0, 0);
        tbl[13].i = stim(0, 0, 0, 0, 0, 0, 'hAA, 0, 0, 31, 1, 0, 0);
        tbl[13].o = expv(0, 0, 0, 31, 'hAA, 0, 0, 0);
        // Older X5, then flushed X4
        tbl[14].i = stim(0, 1, 1, 0, 5, 'h50, 0, 0, 0, 0, 0, 0, 0);
        tbl[14].o = expv(5, 'h50, 1, 0, 0, 0, 0, 0);
        tbl[15].i = stim(0, 1, 1, 0, 4, 'h40, 0, 0, 1, 0, 0, 0, 0);
        tbl[15].o = expv(4, 'h40, 0, 5, 'h50, 1, 1, 0);
        tbl[16].i = idle;
        tbl[16].o = expv(0, 0, 0, 4, 'h40, 0, 0, 0);
        tbl[17].i = idle;
        tbl[17].o = expv(0, 0, 0, 0, 0, 0, 0, 0);

        drive(idle);
        for (int k = 0; k < 18; k++) begin
            step(tbl[k].i, $sformatf("vec%0d", k), tbl[k].o);
        end
`ifdef FWD_SOURCE_STATS_EN
        chk("stallCount.table", 64'(stallCount), 64'd2);
`endif

        // X9 reaches MEM/WB, X10 in EX/MEM, then 3 stalled cycles with flush asserted.
        step(stim(0, 1, 1, 0, 9, 'h9, 0, 0, 0, 0, 0, 0, 0), "stl.s1", expv(9, 'h9, 1, 0, 0, 0, 0, 0));
        step(stim(0, 1, 1, 0, 10, 'hA, 0, 0, 0, 0, 0, 0, 0), "stl.s2",
             expv(10, 'hA, 1, 9, 'h9, 1, 1, 0));
        drive(stim(0, 1, 1, 0, 11, 'hB, 0, 1, 1, 0, 0, 0, 0));
        #1;
        chk("stl.first_cycle.wbWrite", 64'(wbWrite), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("stl.hold%0d", k), expv(10, 'hA, 1, 9, 'h9, 1, 0, 0));
        end
        step(idle, "stl.release", expv(0, 0, 0, 10, 'hA, 1, 1, 0));
        step(idle, "stl.drain", expv(0, 0, 0, 0, 0, 0, 0, 0));

        // Load-use held under memStall: stall stays up, counter frozen, late load data used.
        step(stim(0, 1, 1, 1, 8, 'h400, 0, 0, 0, 8, 1, 0, 0), "lus.l1",
             expv(8, 'h400, 0, 0, 0, 0, 0, 1));
        for (int k = 0; k < 2; k++) begin
            step(stim(0, 0, 0, 0, 0, 0, 'h1234, 1, 0, 8, 1, 0, 0), $sformatf("lus.hold%0d", k),
                 expv(8, 'h400, 0, 0, 0, 0, 0, 1));
        end
`ifdef FWD_SOURCE_STATS_EN
        chk("stallCount.frozen", 64'(stallCount), 64'd2);
`endif
        step(stim(0, 0, 0, 0, 0, 0, 'hCAFE, 0, 0, 8, 1, 0, 0), "lus.l3",
             expv(0, 0, 0, 8, 'hCAFE, 1, 1, 0));
`ifdef FWD_SOURCE_STATS_EN
        chk("stallCount.after", 64'(stallCount), 64'd3);
`endif

        // Reset wins over memStall and flush.
        step(stim(0, 1, 1, 0, 6, 'h66, 0, 0, 0, 0, 0, 0, 0), "rst.pre",
             expv(6, 'h66, 1, 0, 0, 0, 0, 0));
        step(stim(1, 1, 1, 0, 6, 'h66, 0, 1, 1, 0, 0, 0, 0), "rst.stall",
             expv(0, 0, 0, 0, 0, 0, 0, 0));
`ifdef FWD_SOURCE_STATS_EN
        chk("stallCount.reset", 64'(stallCount), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
